// File: rtl/button_conditioner.sv
// Debounces a synchronized push-button level and produces press / release pulses.
// Define BUTTON_AUTOREPEAT_EN to enable timed auto-repeat press pulses while the button is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 2) && (REPEAT_PERIOD >= 1);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("button_conditioner: DEBOUNCE_CYCLES>=1, REPEAT_DELAY>=2, REPEAT_PERIOD>=1 required");
        end
    endgenerate

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic [DB_W-1:0] db_count;
    logic            accept;
    logic            level_rise;
    logic            level_fall;

    // accept marks the edge that takes the last required differing sample
    assign accept     = (in != level) && (db_count == DB_LAST);
    assign level_rise = accept && !level;
    assign level_fall = accept && level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_count <= '0;
            level    <= 1'b0;
        end else if (in == level) begin
            db_count <= '0;
        end else if (accept) begin
            db_count <= '0;
            level    <= ~level;
        end else begin
            db_count <= db_count + DB_ONE;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        HELD_DELAY,
        HELD_REPEAT
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_count;
    logic [HOLD_W-1:0] hold_next;

    // Saturating increment so a stuck counter can never wrap into a false match
    assign hold_next = (hold_count == '1) ? hold_count : hold_count + HOLD_ONE;

    // A falling level overrides any repeat that would land on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hold_count    <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (level_fall) begin
                state         <= IDLE;
                hold_count    <= '0;
                release_pulse <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (level_rise) begin
                            state      <= HELD_DELAY;
                            hold_count <= HOLD_ONE;
                            press      <= 1'b1;
                        end
                    end
                    HELD_DELAY: begin
                        if (hold_count == HOLD_DELAY) begin
                            state      <= HELD_REPEAT;
                            hold_count <= HOLD_ONE;
                            press      <= 1'b1;
                        end else begin
                            hold_count <= hold_next;
                        end
                    end
                    HELD_REPEAT: begin
                        if (hold_count == HOLD_PERIOD) begin
                            hold_count <= HOLD_ONE;
                            press      <= 1'b1;
                        end else begin
                            hold_count <= hold_next;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        hold_count <= '0;
                    end
                endcase
            end
        end
    end

`else

    typedef enum logic {
        IDLE,
        HELD_DELAY
    } state_t;

    state_t state;

    // Without auto-repeat the held state only waits for the button to be let go
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (level_fall) begin
                state         <= IDLE;
                release_pulse <= 1'b1;
            end else if (state == IDLE && level_rise) begin
                state <= HELD_DELAY;
                press <= 1'b1;
            end
        end
    end

`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner, checked against a cycle-count model of the button rules.
// Follows the DUT build: define BUTTON_AUTOREPEAT_EN for both to exercise auto-repeat.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in;
    logic level;
    logic press;
    logic release_pulse;

    int compared   = 0;
    int mismatched = 0;

    int   mRun;
    logic mLevel;
    logic mPress;
    logic mRelease;
    int   mSince;
    bit   mRepeating;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mRun       = 0;
        mLevel     = 1'b0;
        mPress     = 1'b0;
        mRelease   = 1'b0;
        mSince     = 0;
        mRepeating = 1'b0;
    endtask

    // One clock edge of the button rules: count differing samples, then time presses
    task automatic modelStep(input logic sample);
        logic prev;
        prev = mLevel;
        if (sample != mLevel) begin
            mRun++;
            if (mRun == DB) begin
                mLevel = ~mLevel;
                mRun   = 0;
            end
        end else begin
            mRun = 0;
        end
        mRelease = prev && !mLevel;
        mPress   = 1'b0;
        if (!prev && mLevel) begin
            mPress     = 1'b1;
            mSince     = 0;
            mRepeating = 1'b0;
        end else if (prev && mLevel) begin
            if (mSince < 1000) mSince++;
            if (AUTO && mSince == (mRepeating ? RP : RD)) begin
                mPress     = 1'b1;
                mSince     = 0;
                mRepeating = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("level", level, mLevel);
        checkOutput("press", press, mPress);
        checkOutput("release_pulse", release_pulse, mRelease);
        checkOutput("press_release_exclusive", press & release_pulse, 1'b0);
    endtask

    // Holds `in` at value for the given number of clock edges, checking after each edge
    task automatic applyStimulus(input logic value, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            in = value;
            @(posedge clk);
            modelStep(value);
            @(negedge clk);
            checkAll();
        end
    endtask

    // Pulses reset between edges and expects every output to drop without a clock
    task automatic asyncResetCheck();
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_level", level, 1'b0);
        checkOutput("async_reset_press", press, 1'b0);
        checkOutput("async_reset_release", release_pulse, 1'b0);
        modelReset();
        #1 reset = 1'b0;
    endtask

    initial begin
        logic value;
        int   len;

        reset = 1'b1;
        in    = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        reset = 1'b0;

        // Glitch shorter than the debounce window, then a clean press held long
        applyStimulus(1'b1, DB - 1);
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 10);

        // Low glitch inside a hold must not release or restart timing
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, DB - 1);
        applyStimulus(1'b1, 15);
        applyStimulus(1'b0, 8);

        // Reset while held with the button still pressed: needs a fresh debounce
        applyStimulus(1'b1, 15);
        in = 1'b1;
        asyncResetCheck();
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 8);

        // Reset mid-debounce
        applyStimulus(1'b1, 2);
        asyncResetCheck();
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 6);

        value = 1'b0;
        for (int s = 0; s < 60; s++) begin
            value = ~value;
            if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, DB - 1);
            end else begin
                len = $urandom_range(DB, 35);
            end
            applyStimulus(value, len);
        end
        applyStimulus(1'b0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
